mem_bus_if: RTL and testbench

//  Data-side bus interface between the MEM stage and a Wishbone-style memory bus.

---
 rtl/mem_bus_if.sv | 163 ++++++++++++++++
 tb/tb_mem_bus_if.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_if.sv
// mem_bus_if: MEM-stage data master for a Wishbone-style bus.
// Stalls the pipeline until ack, and abandons on flush or timeout.
module mem_bus_if #(
  parameter int STAGE_IDX = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq,
  output logic        bus_err_o,
  input  logic [31:0] wb_data_i,
  input  logic        wb_ack_i,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY       = 2'd1,
    WAIT_STALL = 2'd2
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] rd_buf_q, rd_buf_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic        hold_stage;

  assign hold_stage = stall_i[STAGE_IDX];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      data_q   <= 32'd0;
      sel_q    <= 4'd0;
      rd_buf_q <= 32'd0;
      cnt_q    <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      sel_q    <= sel_d;
      rd_buf_q <= rd_buf_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    we_d     = we_q;
    addr_d   = addr_q;
    data_d   = data_q;
    sel_d    = sel_q;
    rd_buf_d = rd_buf_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = cpu_we_i;
          addr_d  = cpu_addr_i;
          data_d  = cpu_data_i;
          sel_d   = cpu_sel_i;
          cnt_d   = 8'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (flush_i) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          state_d = IDLE;
        end else if (wb_ack_i) begin
          cyc_d    = 1'b0;
          stb_d    = 1'b0;
          we_d     = 1'b0;
          addr_d   = 32'd0;
          data_d   = 32'd0;
          sel_d    = 4'd0;
          rd_buf_d = wb_data_i;
          state_d  = hold_stage ? WAIT_STALL : IDLE;
        end else if (cnt_q == CNT_LAST) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_STALL: begin
        // result already taken; only wait for the pipeline to move on
        if (flush_i || !hold_stage) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stallreq   = 1'b0;
    cpu_data_o = 32'd0;
    unique case (state_q)
      IDLE: stallreq = cpu_ce_i & ~flush_i;
      BUSY: begin
        if (flush_i) begin
          stallreq = 1'b0;
        end else if (wb_ack_i) begin
          cpu_data_o = we_q ? 32'd0 : wb_data_i;
        end else begin
          stallreq = 1'b1;
        end
      end
      WAIT_STALL: cpu_data_o = rd_buf_q;
      default: ;
    endcase
  end

  assign wb_addr_o = addr_q;
  assign wb_data_o = data_q;
  assign wb_sel_o  = sel_q;
  assign wb_we_o   = we_q;
  assign wb_stb_o  = stb_q;
  assign wb_cyc_o  = cyc_q;
  assign bus_err_o = err_q;

endmodule

// File: tb/tb_mem_bus_if.sv
// tb_mem_bus_if: directed + random bench for mem_bus_if,
// checked every cycle against a transaction-level model.
module tb_mem_bus_if;

  localparam int TO  = 4;
  localparam int IDX = 4;

  logic        clk;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        cpu_ce_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_i;
  logic [31:0] cpu_data_o;
  logic        stallreq;
  logic        bus_err_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;

  int n_chk  = 0;
  int n_fail = 0;

  mem_bus_if #(.STAGE_IDX(IDX), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i),
    .cpu_addr_i(cpu_addr_i), .cpu_sel_i(cpu_sel_i),
    .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .stallreq(stallreq), .bus_err_o(bus_err_o),
    .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  // Transaction-level view: an open bus transfer, a held result,
  // and the values the bus outputs are expected to carry.
  bit          m_ok = 0;
  bit          x_open = 0;
  bit          x_held = 0;
  int          x_age = 0;
  bit          x_we = 0;
  logic [31:0] x_addr = 0;
  logic [31:0] x_data = 0;
  logic [3:0]  x_sel = 0;
  bit          x_cyc = 0;
  bit          x_err = 0;
  logic [31:0] x_rdbuf = 0;

  always @(negedge clk) begin
    logic        e_stall;
    logic [31:0] e_cdata;
    bit          err_n;
    if (m_ok) begin
      e_stall = 1'b0;
      e_cdata = 32'd0;
      if (x_open) begin
        if (flush_i) e_stall = 1'b0;
        else if (wb_ack_i) e_cdata = x_we ? 32'd0 : wb_data_i;
        else e_stall = 1'b1;
      end else if (x_held) begin
        e_cdata = x_rdbuf;
      end else begin
        e_stall = cpu_ce_i & ~flush_i;
      end
      chk("stallreq", {31'd0, stallreq}, {31'd0, e_stall});
      chk("cpu_data_o", cpu_data_o, e_cdata);
      chk("bus_err_o", {31'd0, bus_err_o}, {31'd0, x_err});
      chk("wb_cyc_o", {31'd0, wb_cyc_o}, {31'd0, x_cyc});
      chk("wb_stb_o", {31'd0, wb_stb_o}, {31'd0, x_cyc});
      chk("wb_we_o", {31'd0, wb_we_o}, {31'd0, x_we});
      chk("wb_addr_o", wb_addr_o, x_addr);
      chk("wb_data_o", wb_data_o, x_data);
      chk("wb_sel_o", {28'd0, wb_sel_o}, {28'd0, x_sel});
    end
    if (!rst) begin
      m_ok = 1; x_open = 0; x_held = 0; x_age = 0;
      x_we = 0; x_addr = 0; x_data = 0; x_sel = 0;
      x_cyc = 0; x_err = 0; x_rdbuf = 0;
    end else if (m_ok) begin
      err_n = 0;
      if (x_open) begin
        if (flush_i) begin
          x_open = 0; x_cyc = 0; x_we = 0;
        end else if (wb_ack_i) begin
          x_open = 0; x_cyc = 0; x_we = 0;
          x_addr = 0; x_data = 0; x_sel = 0;
          x_rdbuf = wb_data_i;
          x_held = stall_i[IDX];
        end else if (x_age == TO - 1) begin
          x_open = 0; x_cyc = 0; err_n = 1;
        end else begin
          x_age++;
        end
      end else if (x_held) begin
        if (flush_i || !stall_i[IDX]) x_held = 0;
      end else if (cpu_ce_i && !flush_i) begin
        x_open = 1; x_cyc = 1; x_age = 0;
        x_we = cpu_we_i; x_addr = cpu_addr_i;
        x_data = cpu_data_i; x_sel = cpu_sel_i;
      end
      x_err = err_n;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit we, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    step();
    cpu_ce_i = 1; cpu_we_i = we; cpu_addr_i = a;
    cpu_data_i = d; cpu_sel_i = s;
    @(negedge clk);
  endtask

  initial begin
    rst = 0; stall_i = 0; flush_i = 0; cpu_ce_i = 0;
    cpu_we_i = 0; cpu_addr_i = 0; cpu_sel_i = 0;
    cpu_data_i = 0; wb_data_i = 0; wb_ack_i = 0;
    step(); step();
    rst = 1;
    @(negedge clk);
    chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rst_addr", wb_addr_o, 32'd0);
    chk("rst_err", {31'd0, bus_err_o}, 32'd0);
    chk("rst_stall", {31'd0, stallreq}, 32'd0);

    // load, ack on third bus cycle
    req(0, 32'h100, 32'h0, 4'hF);
    chk("ld_req_stall", {31'd0, stallreq}, 32'd1);
    chk("ld_req_cyc", {31'd0, wb_cyc_o}, 32'd0);
    step(); @(negedge clk);
    chk("ld_stb1", {31'd0, wb_stb_o}, 32'd1);
    chk("ld_addr", wb_addr_o, 32'h100);
    chk("ld_sel", {28'd0, wb_sel_o}, 32'hF);
    step(); @(negedge clk);
    chk("ld_stall2", {31'd0, stallreq}, 32'd1);
    step(); wb_ack_i = 1; wb_data_i = 32'hDEADBEEF;
    @(negedge clk);
    chk("ld_stb3", {31'd0, wb_stb_o}, 32'd1);
    chk("ld_ack_stall", {31'd0, stallreq}, 32'd0);
    chk("ld_ack_data", cpu_data_o, 32'hDEADBEEF);
    step(); wb_ack_i = 0; cpu_ce_i = 0;
    @(negedge clk);
    chk("ld_done_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("ld_done_addr", wb_addr_o, 32'd0);

    // store
    req(1, 32'h200, 32'h12345678, 4'h3);
    step(); @(negedge clk);
    chk("st_we", {31'd0, wb_we_o}, 32'd1);
    chk("st_sel", {28'd0, wb_sel_o}, 32'h3);
    chk("st_data", wb_data_o, 32'h12345678);
    step(); wb_ack_i = 1; wb_data_i = 32'hFFFFFFFF;
    @(negedge clk);
    chk("st_ack_cdata", cpu_data_o, 32'd0);
    chk("st_ack_data", wb_data_o, 32'h12345678);
    step(); wb_ack_i = 0; cpu_ce_i = 0;
    @(negedge clk);
    chk("st_done_we", {31'd0, wb_we_o}, 32'd0);

    // ack while MEM is frozen by a later stage
    req(0, 32'h300, 32'h0, 4'hF);
    step(); wb_ack_i = 1; wb_data_i = 32'hCAFEF00D;
    stall_i = 6'b010000;
    @(negedge clk);
    chk("ws_ack_data", cpu_data_o, 32'hCAFEF00D);
    for (int i = 0; i < 2; i++) begin
      step(); wb_ack_i = 0; wb_data_i = 32'h0;
      @(negedge clk);
      chk("ws_cyc", {31'd0, wb_cyc_o}, 32'd0);
      chk("ws_stall", {31'd0, stallreq}, 32'd0);
      chk("ws_data", cpu_data_o, 32'hCAFEF00D);
    end
    step(); stall_i = 0; cpu_ce_i = 0;
    @(negedge clk);
    chk("ws_last", cpu_data_o, 32'hCAFEF00D);
    step(); @(negedge clk);
    chk("ws_idle_data", cpu_data_o, 32'd0);
    chk("ws_idle_cyc", {31'd0, wb_cyc_o}, 32'd0);

    // flush together with ack
    req(0, 32'h400, 32'h0, 4'hF);
    step(); flush_i = 1; wb_ack_i = 1; wb_data_i = 32'h11111111;
    @(negedge clk);
    chk("fl_ack_stall", {31'd0, stallreq}, 32'd0);
    chk("fl_ack_data", cpu_data_o, 32'd0);
    step(); flush_i = 0; wb_ack_i = 0; cpu_ce_i = 0;
    @(negedge clk);
    chk("fl_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("fl_stb", {31'd0, wb_stb_o}, 32'd0);

    // flush alone mid-transfer
    req(1, 32'h480, 32'hA5A5A5A5, 4'hC);
    step(); cpu_ce_i = 0; @(negedge clk);
    chk("fl2_busy", {31'd0, stallreq}, 32'd1);
    step(); flush_i = 1; @(negedge clk);
    chk("fl2_stall", {31'd0, stallreq}, 32'd0);
    step(); flush_i = 0; @(negedge clk);
    chk("fl2_cyc", {31'd0, wb_cyc_o}, 32'd0);

    // timeout after TO bus cycles
    req(0, 32'h500, 32'h0, 4'hF);
    for (int i = 0; i < TO; i++) begin
      step(); cpu_ce_i = 0; @(negedge clk);
      chk("to_cyc", {31'd0, wb_cyc_o}, 32'd1);
      chk("to_err0", {31'd0, bus_err_o}, 32'd0);
    end
    step(); @(negedge clk);
    chk("to_drop", {31'd0, wb_cyc_o}, 32'd0);
    chk("to_err", {31'd0, bus_err_o}, 32'd1);
    chk("to_stall", {31'd0, stallreq}, 32'd0);
    step(); @(negedge clk);
    chk("to_err_off", {31'd0, bus_err_o}, 32'd0);

    // reset mid-transfer, then a late ack
    req(1, 32'h600, 32'h77, 4'h1);
    step(); cpu_ce_i = 0; rst = 0; @(negedge clk);
    chk("rs_busy", {31'd0, wb_cyc_o}, 32'd1);
    step(); rst = 1; wb_ack_i = 1; wb_data_i = 32'h55;
    @(negedge clk);
    chk("rs_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rs_addr", wb_addr_o, 32'd0);
    chk("rs_cdata", cpu_data_o, 32'd0);
    step(); wb_ack_i = 0; @(negedge clk);
    chk("rs_late", {31'd0, wb_cyc_o}, 32'd0);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      step();
      rst        = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      flush_i    = ($urandom_range(0, 15) == 0);
      cpu_ce_i   = ($urandom_range(0, 9) < 6);
      cpu_we_i   = 1'($urandom);
      cpu_addr_i = $urandom;
      cpu_sel_i  = 4'($urandom);
      cpu_data_i = $urandom;
      stall_i    = 6'($urandom);
      wb_ack_i   = ($urandom_range(0, 9) < 4);
      wb_data_i  = $urandom;
    end
    step();
    rst = 1; flush_i = 0; cpu_ce_i = 0; wb_ack_i = 0; stall_i = 0;
    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
